// File: rtl/cross_product_scheduler.sv
// Round-robin arbiter sharing one 3-stage pipelined signed cross-product unit between NREQ requesters.
// Result for a triple granted in cycle T appears with res_valid in cycle T+3, tagged with the requester id.
module cross_product_scheduler #(
    parameter int NREQ    = 2,
    parameter int COORD_W = 10,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*2*COORD_W-1:0]     req_ref,
    input  logic [NREQ*2*COORD_W-1:0]     req_p1,
    input  logic [NREQ*2*COORD_W-1:0]     req_p2,
    output logic                          res_valid,
    output logic [ID_W-1:0]               res_id,
    output logic signed [2*COORD_W+1:0]   res_value,
    output logic                          res_pos,
    output logic                          res_zero,
    output logic                          busy
);

    localparam int PW = 2 * COORD_W;
    localparam int DW = COORD_W + 1;
    localparam int MW = 2 * COORD_W + 1;
    localparam int RW = 2 * COORD_W + 2;

    function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        rr_next;
    logic [ID_W-1:0]        gnt_id;
    logic                   gnt_any;
    logic [NREQ-1:0]        gnt;
    logic [PW-1:0]          sel_ref;
    logic [PW-1:0]          sel_p1;
    logic [PW-1:0]          sel_p2;

    logic                   s1_v;
    logic [ID_W-1:0]        s1_id;
    logic signed [DW-1:0]   s1_dx1;
    logic signed [DW-1:0]   s1_dy1;
    logic signed [DW-1:0]   s1_dx2;
    logic signed [DW-1:0]   s1_dy2;

    logic                   s2_v;
    logic [ID_W-1:0]        s2_id;
    logic signed [MW-1:0]   s2_a;
    logic signed [MW-1:0]   s2_b;

    logic signed [MW-1:0]   m_dx1;
    logic signed [MW-1:0]   m_dy1;
    logic signed [MW-1:0]   m_dx2;
    logic signed [MW-1:0]   m_dy2;
    logic signed [RW-1:0]   diff_r;

    // First valid requester at or after rr_ptr (wrapping) wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        rr_next = rr_ptr;
        sel_ref = '0;
        sel_p1  = '0;
        sel_p2  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt     = NREQ'(1) << idx;
                gnt_id  = ID_W'(idx);
                rr_next = ID_W'((idx + 1) % NREQ);
                sel_ref = req_ref[idx*PW +: PW];
                sel_p1  = req_p1[idx*PW +: PW];
                sel_p2  = req_p2[idx*PW +: PW];
            end
        end
    end

    assign req_ready = reset ? gnt : '0;

    assign m_dx1  = MW'(s1_dx1);
    assign m_dy1  = MW'(s1_dy1);
    assign m_dx2  = MW'(s1_dx2);
    assign m_dy2  = MW'(s1_dy2);
    assign diff_r = RW'(s2_a) - RW'(s2_b);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_value <= '0;
            res_pos   <= 1'b0;
            res_zero  <= 1'b0;
        end else begin
            s1_v      <= gnt_any;
            s2_v      <= s1_v;
            res_valid <= s2_v;
            if (gnt_any) begin
                rr_ptr <= rr_next;
                s1_id  <= gnt_id;
                s1_dx1 <= diff(sel_p1[PW-1:COORD_W], sel_ref[PW-1:COORD_W]);
                s1_dy1 <= diff(sel_p1[COORD_W-1:0],  sel_ref[COORD_W-1:0]);
                s1_dx2 <= diff(sel_p2[PW-1:COORD_W], sel_ref[PW-1:COORD_W]);
                s1_dy2 <= diff(sel_p2[COORD_W-1:0],  sel_ref[COORD_W-1:0]);
            end
            if (s1_v) begin
                s2_id <= s1_id;
                s2_a  <= m_dx1 * m_dy2;
                s2_b  <= m_dx2 * m_dy1;
            end
            // Result fields hold between pulses.
            if (s2_v) begin
                res_id    <= s2_id;
                res_value <= diff_r;
                res_pos   <= !diff_r[RW-1] && (diff_r != '0);
                res_zero  <= (diff_r == '0);
            end
        end
    end

    assign busy = s1_v | s2_v | res_valid;

endmodule

// File: tb/tb_cross_product_scheduler.sv
// Scoreboard bench for cross_product_scheduler: driver predicts grants and results from the arithmetic
// definition, a negedge monitor pops expectations whenever res_valid is seen.
module tb_cross_product_scheduler;
    localparam int NREQ = 2;
    localparam int CW   = 10;
    localparam int IDW  = 2;
    localparam int PW   = 2 * CW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*PW-1:0]   req_ref;
    logic [NREQ*PW-1:0]   req_p1;
    logic [NREQ*PW-1:0]   req_p2;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic signed [PW+1:0] res_value;
    logic                 res_pos;
    logic                 res_zero;
    logic                 busy;

    cross_product_scheduler #(.NREQ(NREQ), .COORD_W(CW), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ref(req_ref), .req_p1(req_p1), .req_p2(req_p2),
        .res_valid(res_valid), .res_id(res_id), .res_value(res_value),
        .res_pos(res_pos), .res_zero(res_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; longint val; int cyc; } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ptr   = 0;
    bit pend[NREQ];
    int rx[NREQ], ry[NREQ], ax[NREQ], ay[NREQ], bx[NREQ], by[NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint cross_of(input int i);
        return longint'(ax[i] - rx[i]) * longint'(by[i] - ry[i])
             - longint'(bx[i] - rx[i]) * longint'(ay[i] - ry[i]);
    endfunction

    task automatic offer(input int i, input int r_x, input int r_y, input int a_x, input int a_y,
                         input int b_x, input int b_y);
        pend[i] = 1'b1;
        rx[i] = r_x; ry[i] = r_y; ax[i] = a_x; ay[i] = a_y; bx[i] = b_x; by[i] = b_y;
    endtask

    task automatic offer_rand(input int i);
        offer(i, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pend[i];
            req_ref[i*PW +: PW]  = {CW'(rx[i]), CW'(ry[i])};
            req_p1[i*PW +: PW]   = {CW'(ax[i]), CW'(ay[i])};
            req_p2[i*PW +: PW]   = {CW'(bx[i]), CW'(by[i])};
        end
    endtask

    // One cycle: present pending requests, predict the round-robin winner, advance to next negedge.
    task automatic step(output int g);
        exp_t e;
        drive();
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        end
        chk("req_ready", longint'(req_ready), (g >= 0) ? (longint'(1) << g) : 0);
        if (g >= 0) begin
            e.id = g; e.val = cross_of(g); e.cyc = cyc + 3;
            q.push_back(e);
            ptr = (g + 1) % NREQ;
            pend[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        ptr = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        @(negedge clk);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("busy", longint'(busy), (q.size() > 0) ? 1 : 0);
            if (res_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_unexpected actual=id%0d/%0d expected=no result", res_id,
                             res_value);
                end else begin
                    e = q.pop_front();
                    chk("res_cycle", longint'(cyc), longint'(e.cyc));
                    chk("res_id", longint'(res_id), longint'(e.id));
                    chk("res_value", longint'(res_value), e.val);
                    chk("res_pos", longint'(res_pos), (e.val > 0) ? 1 : 0);
                    chk("res_zero", longint'(res_zero), (e.val == 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        int g;
        int seq[$];
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            rx[i] = 0; ry[i] = 0; ax[i] = 0; ay[i] = 0; bx[i] = 0; by[i] = 0;
        end
        drive();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_id", longint'(res_id), 0);
        chk("rst_res_value", longint'(res_value), 0);
        chk("rst_res_pos", longint'(res_pos), 0);
        chk("rst_res_zero", longint'(res_zero), 0);
        chk("rst_busy", longint'(busy), 0);
        offer(0, 1, 2, 3, 4, 5, 6);
        drive();
        #1;
        chk("rst_ready_forced", longint'(req_ready), 0);
        pend[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // both requesters continuously valid right after reset: 0,1,0,1,0,1
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++) if (!pend[i]) offer_rand(i);
            step(g);
            seq.push_back(g);
        end
        for (int n = 0; n < 6; n++) chk("fair_grant", longint'(seq[n]), n % 2);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (4) step(g);

        offer(0, 0, 0, 2, 0, 0, 3);        step(g);
        offer(1, 0, 0, 0, 3, 2, 0);        step(g);
        offer(0, 5, 5, 7, 7, 9, 9);        step(g);
        offer(1, 0, 0, 1023, 0, 0, 1023);  step(g);
        offer(0, 0, 0, 0, 1023, 1023, 0);  step(g);
        repeat (4) step(g);

        // reset with two ops in flight: they must vanish, and req0 wins next
        offer(0, 1, 1, 100, 3, 7, 200);
        offer(1, 9, 9, 50, 60, 70, 80);
        step(g);
        step(g);
        do_reset();
        repeat (4) step(g);
        offer_rand(0);
        offer_rand(1);
        step(g);
        chk("post_reset_grant", longint'(g), 0);
        step(g);
        repeat (4) step(g);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) offer_rand(i);
                else if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
            end
            step(g);
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (6) step(g);
        chk("scoreboard_drained", longint'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
